// File: rtl/poly_mult_tile_engine.sv
// Tiled polynomial multiplier: a TILE_WIDTH-lane MAC row accumulates A*B, linear or mod x^N+1.
// Latency: (N/TW)^2*(TW+1) + beats + 2 cycles per job with no stalls; one tile pair per TW+1 cycles.
// Backpressure: tile_ready is high only in LOAD; each result beat holds stable until out_ready.
module poly_mult_tile_engine #(
  parameter int POLY_WIDTH = 128,
  parameter int TILE_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int NEGACYCLIC = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             tile_valid,
  output logic                             tile_ready,
  input  logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_a,
  input  logic [TILE_WIDTH*DATA_WIDTH-1:0] tile_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TILE_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic                             busy,
  output logic                             done
);

  localparam int N       = POLY_WIDTH;
  localparam int TW      = TILE_WIDTH;
  localparam int DW      = DATA_WIDTH;
  localparam int NT      = N / TW;                         // tiles per polynomial
  localparam int ACC_LEN = 2 * N;                          // covers the full linear product
  localparam int OUT_LEN = (NEGACYCLIC != 0) ? N : 2 * N - 1;
  localparam int NB      = (OUT_LEN + TW - 1) / TW;        // result beats per job
  localparam int IW      = (NT > 1) ? $clog2(NT) : 1;
  localparam int MW      = (TW > 1) ? $clog2(TW) : 1;
  localparam int KW      = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW      = $clog2(ACC_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  // Coefficient buffer; in negacyclic mode the upper half is never written and stays zero.
  logic [DW-1:0]   r_acc [ACC_LEN];
  logic [DW-1:0]   r_a   [TW];
  logic [DW-1:0]   r_b   [TW];

  logic [IW-1:0]   r_i;          // A tile index (outer)
  logic [IW-1:0]   r_j;          // B tile index (inner)
  logic [MW-1:0]   r_m;          // MAC cycle within the current pair, selects a[m]
  logic [KW-1:0]   r_k;          // output beat index

  logic [DW-1:0]   w_prod [TW];  // a[m]*b[l], low DW bits
  logic [SW-1:0]   w_s    [TW];  // raw product degree p+q per lane
  logic [SW-1:0]   w_idx  [TW];  // accumulator slot after negacyclic fold
  logic            w_sub  [TW];  // lane wrapped past x^N, so subtract
  logic [SW-1:0]   w_oidx [TW];  // accumulator slot feeding each output lane

  logic            w_mac_last;
  logic            w_last_pair;
  logic            w_last_beat;
  logic            w_load_fire;

  assign w_mac_last  = (r_m == MW'(TW - 1));
  assign w_last_pair = (r_i == IW'(NT - 1)) && (r_j == IW'(NT - 1));
  assign w_last_beat = (r_k == KW'(NB - 1));
  assign w_load_fire = (r_state == S_LOAD) && tile_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake/status outputs, all decoded from the current state.
  always_comb begin
    w_next_state = r_state;
    tile_ready   = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        tile_ready = 1'b1;
        if (tile_valid) begin
          w_next_state = S_MAC;
        end
      end
      S_MAC: begin
        if (w_mac_last) begin
          w_next_state = w_last_pair ? S_STREAM : S_LOAD;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        if (out_ready && w_last_beat) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Tile, MAC-cycle and beat counters; i is outer, j is inner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i <= '0;
      r_j <= '0;
      r_m <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i <= '0;
            r_j <= '0;
            r_m <= '0;
            r_k <= '0;
          end
        end
        S_LOAD: begin
          r_m <= '0;
        end
        S_MAC: begin
          if (w_mac_last) begin
            r_m <= '0;
            if (r_j == IW'(NT - 1)) begin
              r_j <= '0;
              r_i <= (r_i == IW'(NT - 1)) ? '0 : r_i + IW'(1);
            end else begin
              r_j <= r_j + IW'(1);
            end
          end else begin
            r_m <= r_m + MW'(1);
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            r_k <= w_last_beat ? '0 : r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture the accepted tile pair for the MAC row.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < TW; l++) begin
        r_a[l] <= '0;
        r_b[l] <= '0;
      end
    end else if (w_load_fire) begin
      for (int l = 0; l < TW; l++) begin
        r_a[l] <= tile_a[l*DW +: DW];
        r_b[l] <= tile_b[l*DW +: DW];
      end
    end
  end

  // Per-lane product and target slot: a[m] against every b lane in one cycle.
  always_comb begin
    for (int l = 0; l < TW; l++) begin
      w_prod[l] = r_a[r_m] * r_b[l];
      w_s[l]    = SW'(r_i) * SW'(TW) + SW'(r_m) + SW'(r_j) * SW'(TW) + SW'(l);
      w_sub[l]  = (NEGACYCLIC != 0) && (w_s[l] >= SW'(N));
      w_idx[l]  = w_sub[l] ? (w_s[l] - SW'(N)) : w_s[l];
    end
  end

  // Accumulator: cleared on reset or job start, updated once per MAC cycle.
  // Lanes of one cycle always land on distinct slots, so the NBAs never collide.
  always_ff @(posedge clk) begin
    if (rst || ((r_state == S_IDLE) && start)) begin
      for (int e = 0; e < ACC_LEN; e++) begin
        r_acc[e] <= '0;
      end
    end else if (r_state == S_MAC) begin
      for (int l = 0; l < TW; l++) begin
        if (w_sub[l]) begin
          r_acc[w_idx[l]] <= r_acc[w_idx[l]] - w_prod[l];
        end else begin
          r_acc[w_idx[l]] <= r_acc[w_idx[l]] + w_prod[l];
        end
      end
    end
  end

  // Output beat: a direct view of the frozen accumulator, zero outside STREAM and past OUT_LEN.
  always_comb begin
    out_data = '0;
    for (int l = 0; l < TW; l++) begin
      w_oidx[l] = SW'(r_k) * SW'(TW) + SW'(l);
    end
    if (r_state == S_STREAM) begin
      for (int l = 0; l < TW; l++) begin
        if (int'(w_oidx[l]) < OUT_LEN) begin
          out_data[l*DW +: DW] = r_acc[w_oidx[l]];
        end
      end
    end
  end

endmodule
